// File: rtl/pid_pkg.sv
// Shared definitions for the multi-channel PID controller.
// Holds the default widths, the signed saturation helper and the record
// that carries per-sample control flags down the pipeline.
package pid_pkg;

    localparam int unsigned PID_NUM_CH = 4;
    localparam int unsigned PID_DATA_W = 32;
    localparam int unsigned PID_COEF_W = 8;
    localparam int unsigned PID_INT_W  = 40;
    localparam int unsigned PID_OUT_W  = 64;
    localparam logic signed [63:0] PID_INT_LIM = (64'sd1 <<< 39) - 64'sd1;

    // Working width of the saturation helper; every saturated quantity must fit in it.
    localparam int unsigned SAT_W = 128;

    // Control flags that travel alongside the datapath registers of one stage.
    typedef struct packed {
        logic valid;
        logic int_sat;
    } pid_stage_t;

    // Clamp x into [lo, hi].
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] x,
        input logic signed [SAT_W-1:0] lo,
        input logic signed [SAT_W-1:0] hi
    );
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/pid_sat.sv
// Parametrised signed saturator.
// Ports:
//   din  - signed input, IN_W bits
//   dout - din clamped to [LO, HI], OUT_W bits (defaults: full OUT_W signed range)
//   sat  - high when clamping changed the value
module pid_sat
    import pid_pkg::*;
#(
    parameter int unsigned IN_W  = 41,
    parameter int unsigned OUT_W = 40,
    parameter logic signed [SAT_W-1:0] HI = {{(SAT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}},
    parameter logic signed [SAT_W-1:0] LO = ~HI
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);

    logic signed [SAT_W-1:0] wide;
    logic signed [SAT_W-1:0] clip;

    assign wide = SAT_W'(din);
    assign clip = sat_signed(wide, LO, HI);
    assign dout = OUT_W'(clip);
    assign sat  = (clip != wide);

endmodule

// File: rtl/pid_mc_controller.sv
// Time-multiplexed multi-channel PID controller, 3-stage pipeline.
//   Stage 1: error, integrator update (clamped) and derivative; channel state written.
//   Stage 2: full-precision kp*e, ki*integ, kd*d.
//   Stage 3: sum and clip to OUT_W.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   in_valid/in_ch           - sample strobe and its channel
//   sig_in, target           - signed measurement and setpoint
//   cfg_we/cfg_ch/cfg_k*     - coefficient write for one channel
//   int_clr                  - per-channel integrator/prev_err clear
//   out_valid/out_ch         - result strobe and its channel
//   ctrl_out/out_sat/int_sat - control output and saturation flags
// Assumes INT_W >= DATA_W so the error fits the integrator adder.
module pid_mc_controller
    import pid_pkg::*;
#(
    parameter int unsigned        NUM_CH  = PID_NUM_CH,
    parameter int unsigned        DATA_W  = PID_DATA_W,
    parameter int unsigned        COEF_W  = PID_COEF_W,
    parameter int unsigned        INT_W   = PID_INT_W,
    parameter logic signed [63:0] INT_LIM = PID_INT_LIM,
    parameter int unsigned        OUT_W   = PID_OUT_W,
    parameter int unsigned        CH_W    = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] sig_in,
    input  logic signed [DATA_W-1:0] target,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic signed [COEF_W-1:0] cfg_kp,
    input  logic signed [COEF_W-1:0] cfg_ki,
    input  logic signed [COEF_W-1:0] cfg_kd,
    input  logic [NUM_CH-1:0]        int_clr,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [OUT_W-1:0]  ctrl_out,
    output logic                     out_sat,
    output logic                     int_sat
);

    localparam int unsigned E_W    = DATA_W + 1;
    localparam int unsigned D_W    = DATA_W + 2;
    localparam int unsigned I_W    = INT_W + 1;
    localparam int unsigned PKP_W  = COEF_W + E_W;
    localparam int unsigned PKI_W  = COEF_W + INT_W;
    localparam int unsigned PKD_W  = COEF_W + D_W;
    // kd*d is always wider than kp*e, so only two candidates for the widest product.
    localparam int unsigned PMAX_W = (PKI_W > PKD_W) ? PKI_W : PKD_W;
    localparam int unsigned SUM_W  = PMAX_W + 2;
    localparam logic signed [SAT_W-1:0] ILIM = SAT_W'(INT_LIM);

    // Per-channel state.
    logic signed [COEF_W-1:0] kp_q    [NUM_CH];
    logic signed [COEF_W-1:0] ki_q    [NUM_CH];
    logic signed [COEF_W-1:0] kd_q    [NUM_CH];
    logic signed [INT_W-1:0]  integ_q [NUM_CH];
    logic signed [E_W-1:0]    prev_q  [NUM_CH];

    // Stage 1 combinational.
    logic                    ch_ok;
    logic                    cfg_ok;
    logic                    accept;
    logic                    clr_sel;
    logic [CH_W-1:0]         sel;
    logic signed [INT_W-1:0] integ_cur;
    logic signed [INT_W-1:0] integ_new;
    logic signed [E_W-1:0]   prev_cur;
    logic signed [E_W-1:0]   err;
    logic signed [I_W-1:0]   integ_sum;
    logic signed [D_W-1:0]   diff;
    logic                    integ_clamped;

    assign ch_ok  = ({1'b0, in_ch} < (CH_W+1)'(NUM_CH));
    assign cfg_ok = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));
    assign sel    = ch_ok ? in_ch : '0;
    assign accept = in_valid && ch_ok;

    // A clear in the same cycle as a sample makes the sample start from zero state.
    assign clr_sel   = int_clr[sel];
    assign integ_cur = clr_sel ? '0 : integ_q[sel];
    assign prev_cur  = clr_sel ? '0 : prev_q[sel];

    assign err       = E_W'(target) - E_W'(sig_in);
    assign integ_sum = I_W'(integ_cur) + I_W'(err);
    assign diff      = D_W'(err) - D_W'(prev_cur);

    pid_sat #(
        .IN_W  (I_W),
        .OUT_W (INT_W),
        .HI    (ILIM),
        .LO    (-ILIM)
    ) u_int_clamp (
        .din  (integ_sum),
        .dout (integ_new),
        .sat  (integ_clamped)
    );

    // Channel state: the sample write takes priority over a clear of the same channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                kp_q[c]    <= '0;
                ki_q[c]    <= '0;
                kd_q[c]    <= '0;
                integ_q[c] <= '0;
                prev_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (int_clr[c]) begin
                    integ_q[c] <= '0;
                    prev_q[c]  <= '0;
                end
            end
            if (accept) begin
                integ_q[sel] <= integ_new;
                prev_q[sel]  <= err;
            end
            if (cfg_we && cfg_ok) begin
                kp_q[cfg_ch] <= cfg_kp;
                ki_q[cfg_ch] <= cfg_ki;
                kd_q[cfg_ch] <= cfg_kd;
            end
        end
    end

    // Stage 1 registers; coefficients are the pre-write values.
    pid_stage_t               s1_q;
    logic [CH_W-1:0]          s1_ch_q;
    logic signed [COEF_W-1:0] s1_kp_q;
    logic signed [COEF_W-1:0] s1_ki_q;
    logic signed [COEF_W-1:0] s1_kd_q;
    logic signed [E_W-1:0]    s1_err_q;
    logic signed [INT_W-1:0]  s1_integ_q;
    logic signed [D_W-1:0]    s1_diff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= '0;
            s1_ch_q    <= '0;
            s1_kp_q    <= '0;
            s1_ki_q    <= '0;
            s1_kd_q    <= '0;
            s1_err_q   <= '0;
            s1_integ_q <= '0;
            s1_diff_q  <= '0;
        end else begin
            s1_q.valid   <= accept;
            s1_q.int_sat <= accept && integ_clamped;
            if (accept) begin
                s1_ch_q    <= in_ch;
                s1_kp_q    <= kp_q[sel];
                s1_ki_q    <= ki_q[sel];
                s1_kd_q    <= kd_q[sel];
                s1_err_q   <= err;
                s1_integ_q <= integ_new;
                s1_diff_q  <= diff;
            end
        end
    end

    // Stage 2: products.
    pid_stage_t              s2_q;
    logic [CH_W-1:0]         s2_ch_q;
    logic signed [PKP_W-1:0] s2_pkp_q;
    logic signed [PKI_W-1:0] s2_pki_q;
    logic signed [PKD_W-1:0] s2_pkd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_q     <= '0;
            s2_ch_q  <= '0;
            s2_pkp_q <= '0;
            s2_pki_q <= '0;
            s2_pkd_q <= '0;
        end else begin
            s2_q <= s1_q;
            if (s1_q.valid) begin
                s2_ch_q  <= s1_ch_q;
                s2_pkp_q <= PKP_W'(s1_kp_q) * PKP_W'(s1_err_q);
                s2_pki_q <= PKI_W'(s1_ki_q) * PKI_W'(s1_integ_q);
                s2_pkd_q <= PKD_W'(s1_kd_q) * PKD_W'(s1_diff_q);
            end
        end
    end

    // Stage 3: sum and clip.
    logic signed [SUM_W-1:0] sum;
    logic signed [OUT_W-1:0] sum_clip;
    logic                    sum_sat;

    assign sum = SUM_W'(s2_pkp_q) + SUM_W'(s2_pki_q) + SUM_W'(s2_pkd_q);

    pid_sat #(
        .IN_W  (SUM_W),
        .OUT_W (OUT_W)
    ) u_out_clip (
        .din  (sum),
        .dout (sum_clip),
        .sat  (sum_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            ctrl_out  <= '0;
            out_sat   <= 1'b0;
            int_sat   <= 1'b0;
        end else begin
            out_valid <= s2_q.valid;
            int_sat   <= s2_q.int_sat;
            out_sat   <= s2_q.valid && sum_sat;
            if (s2_q.valid) begin
                out_ch   <= s2_ch_q;
                ctrl_out <= sum_clip;
            end
        end
    end

endmodule
